// File: rtl/eth_pkg.sv
// Shared Ethernet types for the echo responder and its frame interfaces.
package eth_pkg;

    typedef logic [47:0] mac_t;

    localparam mac_t MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR_OUT = 2'd1,
        FORWARD = 2'd2,
        DROP    = 2'd3
    } echo_state_t;

endpackage

// File: rtl/AXIS_IF.sv
// AXI-Stream payload bundle with a single-bit tuser error flag.
interface AXIS_IF #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport Receiver    (input tdata, tkeep, tvalid, tlast, tuser, output tready);
    modport Transmitter (output tdata, tkeep, tvalid, tlast, tuser, input tready);

endinterface

// File: rtl/ETH_HEADER_IF.sv
// Parsed Ethernet header handshake bundle.
interface ETH_HEADER_IF;
    import eth_pkg::*;

    logic        valid;
    logic        ready;
    mac_t        dest_mac;
    mac_t        src_mac;
    logic [15:0] eth_type;

    modport Receiver    (input valid, dest_mac, src_mac, eth_type, output ready);
    modport Transmitter (output valid, dest_mac, src_mac, eth_type, input ready);

endinterface

// File: rtl/eth_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module eth_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/eth_echo_responder.sv
// Echoes frames addressed to this station back to their sender; everything
// else is drained from the payload stream and counted as dropped.
module eth_echo_responder
    import eth_pkg::*;
#(
    parameter int   DATA_WIDTH       = 8,
    parameter bit   KEEP_ENABLE      = (DATA_WIDTH > 8),
    parameter mac_t LOCAL_MAC        = 48'h02_00_00_00_00_01,
    parameter bit   ACCEPT_BROADCAST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    ETH_HEADER_IF.Receiver    eth_header_in_if,
    AXIS_IF.Receiver          eth_payload_in_if,
    ETH_HEADER_IF.Transmitter eth_header_out_if,
    AXIS_IF.Transmitter       eth_payload_out_if,
    output logic [31:0]       frames_echoed,
    output logic [31:0]       frames_dropped,
    output logic              busy
);

    echo_state_t state;
    mac_t        reply_dest;
    mac_t        reply_src;
    logic [15:0] reply_type;

    logic hdr_fire;
    logic beat_fire;
    logic last_fire;
    logic accept;

    assign hdr_fire  = (state == IDLE) && eth_header_in_if.valid;
    assign beat_fire = eth_payload_in_if.tvalid && eth_payload_in_if.tready;
    assign last_fire = beat_fire && eth_payload_in_if.tlast;

    // A group-address source is never a legal reply destination.
    assign accept = ((eth_header_in_if.dest_mac == LOCAL_MAC) ||
                     (ACCEPT_BROADCAST && (eth_header_in_if.dest_mac == MAC_BROADCAST))) &&
                    !eth_header_in_if.src_mac[40];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            reply_dest <= '0;
            reply_src  <= '0;
            reply_type <= '0;
        end else begin
            case (state)
                IDLE: if (hdr_fire) begin
                    reply_dest <= eth_header_in_if.src_mac;
                    reply_src  <= LOCAL_MAC;
                    reply_type <= eth_header_in_if.eth_type;
                    state      <= accept ? HDR_OUT : DROP;
                end
                HDR_OUT: if (eth_header_out_if.ready) state <= FORWARD;
                FORWARD: if (last_fire) state <= IDLE;
                DROP:    if (last_fire) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    assign eth_header_in_if.ready     = (state == IDLE);
    assign eth_header_out_if.valid    = (state == HDR_OUT);
    assign eth_header_out_if.dest_mac = reply_dest;
    assign eth_header_out_if.src_mac  = reply_src;
    assign eth_header_out_if.eth_type = reply_type;

    // Payload path is purely combinational so FORWARD adds no latency.
    assign eth_payload_out_if.tvalid = (state == FORWARD) && eth_payload_in_if.tvalid;
    assign eth_payload_out_if.tdata  = eth_payload_in_if.tdata;
    assign eth_payload_out_if.tlast  = eth_payload_in_if.tlast;
    assign eth_payload_out_if.tuser  = eth_payload_in_if.tuser;
    assign eth_payload_in_if.tready  = (state == FORWARD) ? eth_payload_out_if.tready
                                                          : (state == DROP);

    generate
        if (KEEP_ENABLE) begin : g_keep
            assign eth_payload_out_if.tkeep = eth_payload_in_if.tkeep;
        end else begin : g_nokeep
            assign eth_payload_out_if.tkeep = '1;
        end
    endgenerate

    eth_sat_counter #(.WIDTH(32)) u_echo_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   ((state == FORWARD) && last_fire),
        .count (frames_echoed)
    );

    eth_sat_counter #(.WIDTH(32)) u_drop_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   ((state == DROP) && last_fire),
        .count (frames_dropped)
    );

endmodule

// File: tb/tb_eth_echo_responder.sv
// Randomized frame bench for eth_echo_responder with a frame-level reference model.
module tb_eth_echo_responder;
    import eth_pkg::*;

    localparam mac_t LOCAL = 48'h02_00_00_00_00_01;
    localparam mac_t BCAST = 48'hFFFF_FFFF_FFFF;
    localparam int   TMO   = 2000;
    localparam int   P_IDLE = 0, P_HDR = 1, P_FWD = 2, P_DROP = 3;

    typedef struct packed {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] typ;
        logic [15:0] len;
    } frm_t;

    logic        clk, reset;
    logic [31:0] echoed, dropped, echoed_b, dropped_b;
    logic        busy, busy_b;

    ETH_HEADER_IF hin(), hout(), hin_b(), hout_b();
    AXIS_IF #(.DATA_WIDTH(8)) pin(), pout(), pin_b(), pout_b();

    eth_echo_responder #(.DATA_WIDTH(8), .LOCAL_MAC(LOCAL), .ACCEPT_BROADCAST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .eth_header_in_if(hin), .eth_payload_in_if(pin),
        .eth_header_out_if(hout), .eth_payload_out_if(pout),
        .frames_echoed(echoed), .frames_dropped(dropped), .busy(busy)
    );

    eth_echo_responder #(.DATA_WIDTH(8), .LOCAL_MAC(LOCAL), .ACCEPT_BROADCAST(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .eth_header_in_if(hin_b), .eth_payload_in_if(pin_b),
        .eth_header_out_if(hout_b), .eth_payload_out_if(pout_b),
        .frames_echoed(echoed_b), .frames_dropped(dropped_b), .busy(busy_b)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;
    frm_t       pend[$];
    logic [9:0] pend_beats[$];
    logic [9:0] exp_beats[$];
    logic [7:0] fb[$];
    logic [7:0] cap_out[$];
    logic       fuser;
    mac_t       cap_dest, cap_src;
    logic [15:0] cap_type;
    int  t_hin = 0, hdr_lat = 0, hv_count = 0, hv_b_count = 0, hold = 0;
    bit  rnd = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Output-side readiness: optional header hold, then random or full throughput.
    initial begin
        hout.ready = 0; pout.tready = 0; hout_b.ready = 1; pout_b.tready = 1;
        forever begin
            @(posedge clk); #1;
            if (hold > 0) begin hout.ready = 0; hold--; end
            else hout.ready = rnd ? ($urandom_range(1) == 1) : 1'b1;
            pout.tready = rnd ? ($urandom_range(2) != 0) : 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (hout_b.valid) hv_b_count++;
    end

    // Reference model: tracks which frame phase the responder must be in and
    // the byte stream it owes, and compares every cycle.
    initial begin
        int          ph;
        frm_t        cur, f;
        logic [31:0] exp_echo, exp_drop;
        logic        exp_tready, acc, hv_prev;
        logic [9:0]  e;
        ph = P_IDLE; exp_echo = 0; exp_drop = 0; hv_prev = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_hdr_valid", hout.valid, 0);
                chk("rst_out_tvalid", pout.tvalid, 0);
                chk("rst_in_tready", pin.tready, 0);
                chk("rst_echoed", echoed, 0);
                chk("rst_dropped", dropped, 0);
                chk("rst_busy", busy, 0);
                chk("rst_hdr_fields", {hout.dest_mac, hout.eth_type}, 0);
                chk("rst_hdr_src", hout.src_mac, 0);
                ph = P_IDLE; exp_echo = 0; exp_drop = 0; hv_prev = 0;
                exp_beats.delete();
            end else begin
                exp_tready = (ph == P_FWD) ? pout.tready : (ph == P_DROP);
                chk("busy", busy, ph != P_IDLE);
                chk("hdr_in_ready", hin.ready, ph == P_IDLE);
                chk("hdr_out_valid", hout.valid, ph == P_HDR);
                chk("out_tvalid", pout.tvalid, (ph == P_FWD) && pin.tvalid);
                chk("in_tready", pin.tready, exp_tready);
                chk("frames_echoed", echoed, exp_echo);
                chk("frames_dropped", dropped, exp_drop);
                if (hout.valid) begin
                    hv_count++;
                    if (!hv_prev) hdr_lat = cyc - t_hin;
                end
                hv_prev = hout.valid;
                case (ph)
                    P_IDLE: if (hin.valid) begin
                        if (pend.size() == 0) chk("pending_frame", 0, 1);
                        else begin
                            f = pend.pop_front();
                            t_hin = cyc;
                            acc = ((f.dest == LOCAL) || (f.dest == BCAST)) && !f.src[40];
                            for (int i = 0; i < int'(f.len); i++) begin
                                e = pend_beats.pop_front();
                                if (acc) exp_beats.push_back(e);
                            end
                            cur = f;
                            ph = acc ? P_HDR : P_DROP;
                        end
                    end
                    P_HDR: begin
                        chk("hdr_dest", hout.dest_mac, cur.src);
                        chk("hdr_src", hout.src_mac, LOCAL);
                        chk("hdr_type", hout.eth_type, cur.typ);
                        if (hout.ready) begin
                            cap_dest = hout.dest_mac; cap_src = hout.src_mac; cap_type = hout.eth_type;
                            ph = P_FWD;
                        end
                    end
                    P_FWD: begin
                        if (pout.tvalid && pout.tready) begin
                            if (exp_beats.size() == 0) chk("beat_expected", 0, 1);
                            else begin
                                e = exp_beats.pop_front();
                                chk("beat_user_last_data", {pout.tuser, pout.tlast, pout.tdata}, e);
                                chk("beat_keep", pout.tkeep, 1);
                                cap_out.push_back(pout.tdata);
                            end
                        end
                        if (pin.tvalid && exp_tready && pin.tlast) begin ph = P_IDLE; exp_echo++; end
                    end
                    default: if (pin.tvalid && pin.tlast) begin ph = P_IDLE; exp_drop++; end
                endcase
            end
        end
    end

    task automatic send_frame(input mac_t dest, input mac_t src, input logic [15:0] typ,
                              input bit gaps, input int rst_beat);
        frm_t f;
        int   t, n;
        n = fb.size();
        f.dest = dest; f.src = src; f.typ = typ; f.len = 16'(n);
        pend.push_back(f);
        for (int i = 0; i < n; i++) pend_beats.push_back({fuser && (i == n - 1), i == n - 1, fb[i]});
        hin.dest_mac = dest; hin.src_mac = src; hin.eth_type = typ; hin.valid = 1;
        t = 0;
        @(negedge clk);
        while (!hin.ready && t < TMO) begin @(negedge clk); t++; end
        chk("hdr_accept_wait", t < TMO, 1);
        @(posedge clk); #1;
        hin.valid = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                pin.tvalid = 0;
                repeat ($urandom_range(2, 1)) @(posedge clk);
                #1;
            end
            pin.tdata = fb[i]; pin.tlast = (i == n - 1); pin.tuser = fuser && (i == n - 1);
            pin.tvalid = 1;
            if (i == rst_beat) begin
                reset = 1;
                @(posedge clk); #1;
                reset = 0; pin.tvalid = 0; pin.tlast = 0;
                return;
            end
            t = 0;
            @(negedge clk);
            while (!pin.tready && t < TMO) begin @(negedge clk); t++; end
            chk("beat_accept_wait", t < TMO, 1);
            @(posedge clk); #1;
        end
        pin.tvalid = 0; pin.tlast = 0; pin.tuser = 0;
    endtask

    initial begin
        int   t, hv0, n;
        mac_t d, s;
        reset = 1;
        hin.valid = 0; hin.dest_mac = 0; hin.src_mac = 0; hin.eth_type = 0;
        pin.tvalid = 0; pin.tdata = 0; pin.tkeep = 1; pin.tlast = 0; pin.tuser = 0;
        hin_b.valid = 0; hin_b.dest_mac = 0; hin_b.src_mac = 0; hin_b.eth_type = 0;
        pin_b.tvalid = 0; pin_b.tdata = 0; pin_b.tkeep = 1; pin_b.tlast = 0; pin_b.tuser = 0;
        fuser = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Unicast echo of DE AD BE EF.
        fb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; cap_out.delete();
        send_frame(LOCAL, 48'h02_11_22_33_44_55, 16'h0800, 0, -1);
        repeat (2) @(posedge clk); #1;
        chk("t1_echoed", echoed, 1);
        chk("t1_dest", cap_dest, 48'h02_11_22_33_44_55);
        chk("t1_src", cap_src, 48'h02_00_00_00_00_01);
        chk("t1_type", cap_type, 16'h0800);
        chk("t1_latency", hdr_lat, 1);
        chk("t1_nbytes", cap_out.size(), 4);
        chk("t1_bytes", {cap_out[0], cap_out[1], cap_out[2], cap_out[3]}, 32'hDEAD_BEEF);

        // Foreign destination, 6 beats, must be drained silently.
        hv0 = hv_count;
        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(48'h02_99_99_99_99_99, 48'h02_11_22_33_44_55, 16'h0800, 0, -1);
        repeat (2) @(posedge clk); #1;
        chk("t2_dropped", dropped, 1);
        chk("t2_echoed", echoed, 1);
        chk("t2_no_hdr_out", hv_count - hv0, 0);

        // Broadcast: echoed here, dropped by the instance with broadcast disabled.
        fb = '{8'h55, 8'hAA};
        send_frame(BCAST, 48'h02_11_22_33_44_55, 16'h0806, 0, -1);
        repeat (2) @(posedge clk); #1;
        chk("t3_bcast_echoed", echoed, 2);
        hin_b.dest_mac = BCAST; hin_b.src_mac = 48'h02_11_22_33_44_55; hin_b.eth_type = 16'h0806;
        hin_b.valid = 1; t = 0;
        @(negedge clk);
        while (!hin_b.ready && t < TMO) begin @(negedge clk); t++; end
        chk("t3b_hdr_wait", t < TMO, 1);
        @(posedge clk); #1;
        hin_b.valid = 0;
        for (int i = 0; i < 2; i++) begin
            pin_b.tdata = 8'(i); pin_b.tlast = (i == 1); pin_b.tvalid = 1; t = 0;
            @(negedge clk);
            while (!pin_b.tready && t < TMO) begin @(negedge clk); t++; end
            chk("t3b_beat_wait", t < TMO, 1);
            @(posedge clk); #1;
        end
        pin_b.tvalid = 0; pin_b.tlast = 0;
        repeat (2) @(posedge clk); #1;
        chk("t3b_dropped", dropped_b, 1);
        chk("t3b_echoed", echoed_b, 0);
        chk("t3b_no_hdr_out", hv_b_count, 0);

        // Multicast source to local MAC.
        fb = '{8'h11};
        send_frame(LOCAL, 48'h01_00_5E_00_00_01, 16'h0800, 0, -1);
        repeat (2) @(posedge clk); #1;
        chk("t4_mcast_dropped", dropped, 2);

        // 64-byte frame with header held off and random payload backpressure.
        fb.delete(); cap_out.delete();
        for (int i = 0; i < 64; i++) fb.push_back(8'($urandom));
        hold = 10; rnd = 1;
        send_frame(LOCAL, 48'h02_AB_CD_EF_01_23, 16'h86DD, 1, -1);
        repeat (2) @(posedge clk); #1;
        chk("t5_echoed", echoed, 3);
        chk("t5_nbytes", cap_out.size(), 64);

        // Random traffic mix.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(3))
                1:       d = BCAST;
                2:       d = LOCAL ^ (48'd1 << $urandom_range(47));
                default: d = LOCAL;
            endcase
            s = {16'($urandom), 32'($urandom)};
            s[40] = ($urandom_range(3) == 0);
            fb.delete();
            n = $urandom_range(20, 1);
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            fuser = $urandom_range(1);
            send_frame(d, s, 16'($urandom), 1, -1);
        end
        fuser = 0; rnd = 0;
        repeat (4) @(posedge clk); #1;

        // Reset while beat 3 of a forwarded frame is on the bus.
        fb = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        send_frame(LOCAL, 48'h02_11_22_33_44_55, 16'h0800, 0, 2);
        @(negedge clk);
        chk("t6_post_rst_busy", busy, 0);
        chk("t6_post_rst_echoed", echoed, 0);
        chk("t6_post_rst_hdr_valid", hout.valid, 0);
        @(posedge clk); #1;
        fb = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50}; cap_out.delete();
        send_frame(LOCAL, 48'h02_11_22_33_44_56, 16'h0800, 0, -1);
        repeat (2) @(posedge clk); #1;
        chk("t7_echoed", echoed, 1);
        chk("t7_dest", cap_dest, 48'h02_11_22_33_44_56);
        chk("t7_nbytes", cap_out.size(), 5);
        chk("drained", exp_beats.size(), 0);
        chk("no_pending", pend.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eth_echo_responder.md
# eth_echo_responder

Ethernet-layer echo responder for the stack's frame interfaces. It consumes parsed frames from the receive-side header/payload interfaces and returns them on the transmit-side header/payload interfaces. Returned frames have the destination set to the original source and the source set to the local MAC. Frames not addressed to the local MAC, or to broadcast when broadcast is enabled, are discarded and counted.

## Interface
- DATA_WIDTH, 8: payload tdata width in bits.
- KEEP_ENABLE, DATA_WIDTH > 8: tkeep is present and passed through.
- LOCAL_MAC, 48'h02_00_00_00_00_01: station address used for filtering and as the reply source.
- ACCEPT_BROADCAST, 1'b1: when 1, destination FF:FF:FF:FF:FF:FF is also accepted.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- eth_header_in_if  ETH_HEADER_IF.Receiver  -  valid, ready, dest_mac[47:0], src_mac[47:0], eth_type[15:0].
- eth_payload_in_if  AXIS_IF.Receiver  DATA_WIDTH  tdata, tkeep, tvalid, tready, tlast, tuser[0].
- eth_header_out_if  ETH_HEADER_IF.Transmitter  -  same fields as the input header.
- eth_payload_out_if  AXIS_IF.Transmitter  DATA_WIDTH  same fields as the input payload.
- frames_echoed  out  32  count of frames completed in FORWARD.
- frames_dropped  out  32  count of frames completed in DROP.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, HDR_OUT, FORWARD, DROP.
- IDLE:
  - eth_header_in_if.ready = 1.
  - eth_payload_in_if.tready = 0.
  - On header handshake, register dest_mac, src_mac and eth_type, then evaluate accept.
- Accept condition: (dest == LOCAL_MAC, or ACCEPT_BROADCAST and dest == all-ones) AND src_mac[40] == 0. Bit 40 is the multicast bit; echoing to a group address is forbidden.
- If accepted, go to HDR_OUT. Otherwise go to DROP.
- HDR_OUT:
  - header_out.valid = 1, with dest_mac = registered src, src_mac = LOCAL_MAC, eth_type = registered type.
  - Fields are held stable until ready.
  - On handshake, go to FORWARD.
- FORWARD:
  - Combinational pass-through: out.tvalid/tdata/tkeep/tlast/tuser = in.*, and in.tready = out.tready.
  - On a tlast beat handshake, go to IDLE and increment frames_echoed. tuser is forwarded unchanged; errored frames are still counted as echoed.
- DROP:
  - in.tready = 1 and out.tvalid = 0.
  - On a tlast beat, go to IDLE and increment frames_dropped.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Outside FORWARD, out.tvalid = 0. Outside HDR_OUT, header_out.valid = 0.

## Timing
- Reset: state IDLE; header_out.valid 0; header_out fields 0; out.tvalid 0; in.tready 0; counters 0; busy 0.
- Header latency: header_out.valid rises exactly 1 cycle after the input header handshake.
- Payload latency: 0 cycles; data path is combinational in FORWARD.
- Frame gap: IDLE is entered the cycle after tlast, so there is a minimum of one bubble cycle between a tlast handshake and the next header acceptance. A header presented during that bubble waits.
- A single-beat frame (tlast on the first beat) is valid in both FORWARD and DROP.
- Backpressure: header_out and payload_out may hold ready low indefinitely. No data loss and no field change while stalled.
- Reset mid-frame: immediate return to IDLE; counters clear. Upstream blocks share the same reset, so no partial frame is resumed.
- Header and payload handshakes never occur in the same cycle.

## Structure
- Shared package eth_pkg holds:
  - typedef mac_t (logic [47:0]).
  - localparam MAC_BROADCAST = 48'hFFFF_FFFF_FFFF.
  - enum echo_state_t {IDLE, HDR_OUT, FORWARD, DROP}.
- One natural sub-module: eth_sat_counter (32-bit saturating counter with increment enable and asynchronous reset), instantiated twice.

## Test plan
- Unicast to LOCAL_MAC from 02:11:22:33:44:55, type 0x0800, 4-byte payload DE AD BE EF -> header_out dest=02:11:22:33:44:55, src=LOCAL_MAC, type 0x0800 one cycle after input handshake; payload identical; frames_echoed=1.
- Dest 02:99:99:99:99:99, 6-byte payload -> no header_out.valid; all 6 beats accepted; frames_dropped=1.
- Broadcast dest with ACCEPT_BROADCAST=1 -> echoed; same frame with ACCEPT_BROADCAST=0 -> dropped.
- src_mac=01:00:5E:00:00:01 to LOCAL_MAC -> dropped; frames_dropped increments.
- header_out.ready low for 10 cycles, then random payload_out backpressure on a 64-byte frame -> header fields stable throughout; output byte stream and tlast position exact; input tready tracks output tready.
- Assert reset during beat 3 of a forwarded frame -> next cycle state IDLE, counters 0, header_out.valid 0; next full frame echoes correctly.
